// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if
//   This interface bundles the hazard-status inputs and the pipeline-control
//   outputs of hazard_stall_ctrl.
//   master : the pipeline side. It drives the ID, EX and MEM status and
//            receives the controls and the counters.
//   slave  : the controller side. It receives the status and drives the
//            controls and the counters.
//   Signals:
//     id_read_a, id_read_b, id_uses_b    ID-stage source operands
//     ex_mem_read, ex_write_reg          ID/EX load status and destination
//     branch_taken, mem_busy             MEM-stage events
//     pc_write, ifid_write, idex_write   pipeline-register load enables
//     idex_bubble, ifid_flush,           nop insertion controls
//     exmem_flush
//     stall_cycles, flush_events         saturating performance counters
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_read_a;
  logic [REG_W-1:0] id_read_b;
  logic             id_uses_b;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_write_reg;
  logic             branch_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             exmem_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_read_a, id_read_b, id_uses_b, ex_mem_read, ex_write_reg,
           branch_taken, mem_busy,
    input  pc_write, ifid_write, idex_write, idex_bubble, ifid_flush,
           exmem_flush, stall_cycles, flush_events
  );

  modport slave (
    input  id_read_a, id_read_b, id_uses_b, ex_mem_read, ex_write_reg,
           branch_taken, mem_busy,
    output pc_write, ifid_write, idex_write, idex_bubble, ifid_flush,
           exmem_flush, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   This is the pipeline sequencing controller for the 5-stage LEGv8 core.
//   It decodes the load-use stalls, the taken-branch flushes and the
//   data-memory freezes into load, bubble and flush controls. The state is
//   registered and the controls are Mealy outputs, so each control responds
//   in the same cycle as the event that causes it.
//   When events coincide, the priority order is:
//     RESET > mem_busy > branch (taken or pending) > load-use.
//   Ports:
//     CLK    rising-edge clock
//     RESET  synchronous, active-high reset
//     bus    hazard_stall_ctrl_if.slave, which carries the status inputs,
//            the control outputs and the counters
module hazard_stall_ctrl #(
  parameter int          REG_W  = 5,
  parameter int unsigned ZR_REG = 31,
  parameter int          CNT_W  = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  hazard_stall_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FREEZE   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             pend_br_q, pend_br_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu_haz;
  logic flush_apply;
  logic pc_we, ifid_we, idex_we, idex_bub, ifid_fl, exmem_fl;

  // Load-use hazard: a load in EX writes a register that ID reads.
  // A load to XZR never creates a hazard.
  always_comb begin
    lu_haz = bus.ex_mem_read &&
             (bus.ex_write_reg != REG_W'(ZR_REG)) &&
             ((bus.ex_write_reg == bus.id_read_a) ||
              (bus.id_uses_b && (bus.ex_write_reg == bus.id_read_b)));
  end

  // Next-state decode and Mealy control outputs.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    idex_bub    = 1'b0;
    ifid_fl     = 1'b0;
    exmem_fl    = 1'b0;
    flush_apply = 1'b0;
    state_d     = ST_RUN;
    pend_br_d   = pend_br_q;

    if (RESET) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      idex_we   = 1'b1;
      idex_bub  = 1'b1;
      ifid_fl   = 1'b1;
      exmem_fl  = 1'b1;
      pend_br_d = 1'b0;
      state_d   = ST_RUN;
    end else if (bus.mem_busy) begin
      // The whole pipe holds. A branch seen while frozen is kept for the release cycle.
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      idex_we   = 1'b0;
      pend_br_d = pend_br_q | bus.branch_taken;
      state_d   = ST_FREEZE;
    end else if (bus.branch_taken || pend_br_q) begin
      // The ID instruction is on the wrong path, so any hazard it raises is moot.
      idex_bub    = 1'b1;
      ifid_fl     = 1'b1;
      exmem_fl    = 1'b1;
      flush_apply = 1'b1;
      pend_br_d   = 1'b0;
      state_d     = ST_RUN;
    end else if (lu_haz && (state_q != ST_LU_STALL)) begin
      // Hold PC and IF/ID for one cycle and send a bubble into EX.
      // After the stall EX holds that bubble, so a new hazard is not taken in LU_STALL.
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_bub = 1'b1;
      state_d  = ST_LU_STALL;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Saturating counter next values. The counters clear while RESET is high.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (RESET) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_we && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (flush_apply && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // State, pending-branch and counter registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_RUN;
      pend_br_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_br_q   <= pend_br_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_write     = pc_we;
  assign bus.ifid_write   = ifid_we;
  assign bus.idex_write   = idex_we;
  assign bus.idex_bubble  = idex_bub;
  assign bus.ifid_flush   = ifid_fl;
  assign bus.exmem_flush  = exmem_fl;
  assign bus.stall_cycles = stall_cnt_q;
  assign bus.flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
//   This is the self-checking bench for hazard_stall_ctrl. The directed stimulus
//   pushes the expected controls and counters for each cycle onto a
//   scoreboard queue. A monitor pops each entry on the falling edge and
//   compares it. A second instance with CNT_W=4 exercises counter saturation.
module tb_hazard_stall_ctrl;

  // Control vector packing: {pc_write, ifid_write, idex_write, idex_bubble, ifid_flush, exmem_flush}
  localparam logic [5:0] C_RUN   = 6'b111_000;
  localparam logic [5:0] C_HOLD  = 6'b000_000;
  localparam logic [5:0] C_FLUSH = 6'b111_111;
  localparam logic [5:0] C_LUS   = 6'b001_100;
  localparam logic [5:0] C_RST   = 6'b001_111;

  typedef struct {
    string      tag;
    logic [5:0] ctl;
    int         sc;
    int         fe;
  } exp_t;

  logic clk;
  logic rst;
  logic rst_sat;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) hif ();
  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(4))  sif ();

  hazard_stall_ctrl #(.REG_W(5), .ZR_REG(31), .CNT_W(16)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (hif.slave)
  );

  hazard_stall_ctrl #(.REG_W(5), .ZR_REG(31), .CNT_W(4)) dut_sat (
    .CLK   (clk),
    .RESET (rst_sat),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks = n_checks + 1;
    if (obs !== exp_v) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge and queue what it should produce.
  task automatic step(input string tag, input logic r,
                      input logic [4:0] ra, input logic [4:0] rb, input logic ub,
                      input logic emr, input logic [4:0] ewr,
                      input logic bt, input logic mb,
                      input logic [5:0] ctl, input int sc, input int fe);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    hif.id_read_a    = ra;
    hif.id_read_b    = rb;
    hif.id_uses_b    = ub;
    hif.ex_mem_read  = emr;
    hif.ex_write_reg = ewr;
    hif.branch_taken = bt;
    hif.mem_busy     = mb;
    e.tag = tag;
    e.ctl = ctl;
    e.sc  = sc;
    e.fe  = fe;
    sb_q.push_back(e);
  endtask

  task automatic idle(input string tag, input logic [5:0] ctl, input int sc, input int fe);
    step(tag, 1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, ctl, sc, fe);
  endtask

  // Compare the mid-cycle outputs against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({e.tag, "_ctl"}, {26'd0, hif.pc_write, hif.ifid_write, hif.idex_write,
                                 hif.idex_bubble, hif.ifid_flush, hif.exmem_flush},
                {26'd0, e.ctl});
      check_val({e.tag, "_stall"}, {16'd0, hif.stall_cycles}, e.sc);
      check_val({e.tag, "_flush"}, {16'd0, hif.flush_events}, e.fe);
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    rst_sat  = 1'b1;
    hif.id_read_a = 5'd1; hif.id_read_b = 5'd2; hif.id_uses_b = 1'b1;
    hif.ex_mem_read = 1'b0; hif.ex_write_reg = 5'd0;
    hif.branch_taken = 1'b0; hif.mem_busy = 1'b0;
    sif.id_read_a = 5'd0; sif.id_read_b = 5'd0; sif.id_uses_b = 1'b0;
    sif.ex_mem_read = 1'b0; sif.ex_write_reg = 5'd0;
    sif.branch_taken = 1'b0; sif.mem_busy = 1'b1;
    repeat (2) @(posedge clk);

    //    tag            rst   ra     rb     ub    emr   ewr    bt    mb    ctl      sc fe
    step("reset",        1'b1, 5'd1,  5'd2,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, C_RST,   0, 0);
    idle("run_idle",                                                        C_RUN,   0, 0);
    // Load-use on register A
    step("lu_a",         1'b0, 5'd3,  5'd2,  1'b1, 1'b1, 5'd3,  1'b0, 1'b0, C_LUS,   0, 0);
    idle("lu_release",                                                      C_RUN,   1, 0);
    idle("lu_after",                                                        C_RUN,   1, 0);
    // XZR destination and an unused B operand do not stall
    step("xzr",          1'b0, 5'd31, 5'd2,  1'b1, 1'b1, 5'd31, 1'b0, 1'b0, C_RUN,   1, 0);
    step("unused_b",     1'b0, 5'd1,  5'd5,  1'b0, 1'b1, 5'd5,  1'b0, 1'b0, C_RUN,   1, 0);
    step("used_b",       1'b0, 5'd1,  5'd5,  1'b1, 1'b1, 5'd5,  1'b0, 1'b0, C_LUS,   1, 0);
    idle("used_b_rel",                                                      C_RUN,   2, 0);
    // A branch and a hazard in the same cycle: the flush wins and no stall state is entered
    step("br_haz",       1'b0, 5'd3,  5'd2,  1'b1, 1'b1, 5'd3,  1'b1, 1'b0, C_FLUSH, 2, 0);
    idle("br_after",                                                        C_RUN,   2, 1);
    step("haz_post_br",  1'b0, 5'd3,  5'd2,  1'b1, 1'b1, 5'd3,  1'b0, 1'b0, C_LUS,   2, 1);
    idle("haz_post_rel",                                                    C_RUN,   3, 1);
    // A four-cycle freeze with a branch in its second cycle
    step("frz1",         1'b0, 5'd1,  5'd2,  1'b1, 1'b0, 5'd0,  1'b0, 1'b1, C_HOLD,  3, 1);
    step("frz2",         1'b0, 5'd1,  5'd2,  1'b1, 1'b0, 5'd0,  1'b1, 1'b1, C_HOLD,  4, 1);
    step("frz3",         1'b0, 5'd1,  5'd2,  1'b1, 1'b0, 5'd0,  1'b0, 1'b1, C_HOLD,  5, 1);
    step("frz4",         1'b0, 5'd1,  5'd2,  1'b1, 1'b0, 5'd0,  1'b0, 1'b1, C_HOLD,  6, 1);
    idle("frz_release",                                                     C_FLUSH, 7, 1);
    idle("frz_after",                                                       C_RUN,   7, 2);
    // Reset in the middle of a freeze with a pending branch
    step("frz_a",        1'b0, 5'd1,  5'd2,  1'b1, 1'b0, 5'd0,  1'b1, 1'b1, C_HOLD,  7, 2);
    step("rst_frz",      1'b1, 5'd1,  5'd2,  1'b1, 1'b0, 5'd0,  1'b0, 1'b1, C_RST,   8, 2);
    idle("post_rst",                                                        C_RUN,   0, 0);
    // mem_busy outranks the hazard, and the hazard is then taken on release
    step("busy_haz",     1'b0, 5'd3,  5'd2,  1'b1, 1'b1, 5'd3,  1'b0, 1'b1, C_HOLD,  0, 0);
    step("rel_haz",      1'b0, 5'd3,  5'd2,  1'b1, 1'b1, 5'd3,  1'b0, 1'b0, C_LUS,   1, 0);
    idle("rel_haz_after",                                                   C_RUN,   2, 0);
    // A branch during LU_STALL still flushes
    step("lu_again",     1'b0, 5'd3,  5'd2,  1'b1, 1'b1, 5'd3,  1'b0, 1'b0, C_LUS,   2, 0);
    step("br_in_lus",    1'b0, 5'd1,  5'd2,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, C_FLUSH, 3, 0);
    idle("br_in_lus_aft",                                                   C_RUN,   3, 1);

    repeat (2) @(posedge clk);
    #1;
    check_val("scoreboard_empty", sb_q.size(), 32'd0);

    // Saturation: a 4-bit counter with mem_busy held for 20 cycles
    @(posedge clk);
    #1;
    rst_sat = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 14) check_val("sat_14", {28'd0, sif.stall_cycles}, 32'd14);
      if (i == 15) check_val("sat_15", {28'd0, sif.stall_cycles}, 32'd15);
      if (i == 20) begin
        check_val("sat_20", {28'd0, sif.stall_cycles}, 32'd15);
        check_val("sat_hold_pc", {31'd0, sif.pc_write}, 32'd0);
        check_val("sat_flush_cnt", {28'd0, sif.flush_events}, 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
